// File: rtl/memorybank_multiport_word_if.sv
// Request/response bundle for the multi-port word memory bank.
// The bank takes the slave modport and its client takes the master modport.
interface memorybank_multiport_word_if #(
    parameter int MEM_WIDTH      = 8,
    parameter int BYTES_PER_WORD = 2,
    parameter int ADDR_WIDTH     = 16
);
    localparam int WORD_WIDTH = MEM_WIDTH * BYTES_PER_WORD;

    logic                      wr_en;
    logic                      rd_en;
    logic [BYTES_PER_WORD-1:0] byte_en;
    logic [ADDR_WIDTH-1:0]     index;
    logic [WORD_WIDTH-1:0]     data_in;
    logic [WORD_WIDTH-1:0]     data_out;
    logic                      rd_valid;
    logic                      ready;
    logic                      addr_err;

    modport master (
        output wr_en, rd_en, byte_en, index, data_in,
        input  data_out, rd_valid, ready, addr_err
    );

    modport slave (
        input  wr_en, rd_en, byte_en, index, data_in,
        output data_out, rd_valid, ready, addr_err
    );
endinterface

// File: rtl/memorybank_multiport_word.sv
// Byte-organised scratch store with word access, per-byte enables, wrap-around
// addressing, a registered write-first read port and a post-reset clear sweep.
module memorybank_multiport_word #(
    parameter int MEM_WIDTH      = 8,
    parameter int BYTES_PER_WORD = 2,
    parameter int MEM_DEPTH      = 16,
    parameter int ADDR_WIDTH     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    memorybank_multiport_word_if.slave  bus
);
    localparam int WORD_WIDTH = MEM_WIDTH * BYTES_PER_WORD;
    localparam int LOC_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int SUM_W      = ((ADDR_WIDTH > LOC_W) ? ADDR_WIDTH : LOC_W) + 1;
    localparam int CMP_W      = ((ADDR_WIDTH > 32) ? ADDR_WIDTH : 32) + 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [LOC_W-1:0]     ptr_q;
    logic [LOC_W-1:0]     ptr_d;
    logic                 ready;
    logic                 clr_we;

    logic [MEM_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                 in_range;
    logic                 wr_fire;
    logic                 rd_fire;
    logic                 bad_req;

    logic [LOC_W-1:0]     loc      [BYTES_PER_WORD];
    logic [MEM_WIDTH-1:0] wr_byte  [BYTES_PER_WORD];
    logic [MEM_WIDTH-1:0] rd_byte  [BYTES_PER_WORD];
    logic                 byte_we  [BYTES_PER_WORD];
    logic [WORD_WIDTH-1:0] rd_word;

    logic [WORD_WIDTH-1:0] data_out_q;
    logic                  rd_valid_q;
    logic                  addr_err_q;

    // State register: reset always restarts the clear sweep from location 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == LOC_W'(MEM_DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + LOC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ready  = (state_q == ST_IDLE);
        clr_we = (state_q == ST_CLEAR);
    end

    // Range check at full index width so high address bits can never alias.
    assign in_range = (CMP_W'(bus.index) < CMP_W'(MEM_DEPTH));
    assign wr_fire  = ready & bus.wr_en & in_range;
    assign rd_fire  = ready & bus.rd_en & in_range;
    assign bad_req  = ready & (bus.wr_en | bus.rd_en) & ~in_range;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_byte
            logic [SUM_W-1:0] sum;
            // index < MEM_DEPTH and gi < MEM_DEPTH, so one conditional subtract wraps it.
            assign sum         = SUM_W'(bus.index) + SUM_W'(gi);
            assign loc[gi]     = (sum >= SUM_W'(MEM_DEPTH)) ? LOC_W'(sum - SUM_W'(MEM_DEPTH))
                                                            : LOC_W'(sum);
            assign wr_byte[gi] = bus.data_in[WORD_WIDTH-1-gi*MEM_WIDTH -: MEM_WIDTH];
            assign byte_we[gi] = wr_fire & bus.byte_en[BYTES_PER_WORD-1-gi];
            assign rd_byte[gi] = byte_we[gi] ? wr_byte[gi] : mem_q[loc[gi]];
            assign rd_word[WORD_WIDTH-1-gi*MEM_WIDTH -: MEM_WIDTH] = rd_byte[gi];
        end
    endgenerate

    // Clear sweep and request writes are mutually exclusive (ready gates requests).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem_q[ptr_q] <= '0;
            end
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                if (byte_we[k]) begin
                    mem_q[loc[k]] <= wr_byte[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            addr_err_q <= bad_req;
            if (rd_fire) begin
                data_out_q <= rd_word;
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.ready    = ready;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_memorybank_multiport_word.sv
// Directed bench for the multi-port word memory bank with hand-computed expectations.
module tb_memorybank_multiport_word;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    memorybank_multiport_word_if #(
        .MEM_WIDTH(8), .BYTES_PER_WORD(2), .ADDR_WIDTH(16)
    ) bus ();

    memorybank_multiport_word #(
        .MEM_WIDTH(8), .BYTES_PER_WORD(2), .MEM_DEPTH(16), .ADDR_WIDTH(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Apply one request for exactly one edge, then sample 1 ns after it.
    task automatic op(input logic wr, input logic rd, input logic [1:0] be,
                      input logic [15:0] idx, input logic [15:0] din);
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.byte_en = be;
        bus.index   = idx;
        bus.data_in = din;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.byte_en = '0;
        bus.index   = '0;
        bus.data_in = '0;
    endtask

    task automatic clear_sweep(input string tag);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 15 || i == 16) check_eq(tag, {31'd0, bus.ready}, {31'd0, (i == 16)});
            else if (bus.ready !== 1'b0) check_eq(tag, {31'd0, bus.ready}, 32'd0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.byte_en = '0;
        bus.index   = '0;
        bus.data_in = '0;

        // 1. reset and clear sweep; requests during clear must be ignored
        @(posedge clk);
        #1;
        check_eq("rst_ready",    {31'd0, bus.ready},    32'd0);
        check_eq("rst_data_out", {16'd0, bus.data_out}, 32'd0);
        check_eq("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check_eq("rst_addr_err", {31'd0, bus.addr_err}, 32'd0);
        rst         = 1'b0;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.byte_en = 2'b11;
        bus.index   = 16'd7;
        bus.data_in = 16'hFFFF;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("clr_ready_e%0d", i), {31'd0, bus.ready}, {31'd0, (i == 16)});
            if (i == 16) begin
                check_eq("clr_no_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
                bus.wr_en = 1'b0;
                bus.rd_en = 1'b0;
            end
        end
        op(1'b0, 1'b1, 2'b00, 16'd7, 16'h0);
        check_eq("clr_rd7_data",  {16'd0, bus.data_out}, 32'h0000);
        check_eq("clr_rd7_valid", {31'd0, bus.rd_valid}, 32'd1);
        op(1'b0, 1'b0, 2'b00, 16'd0, 16'h0);
        check_eq("rd_valid_pulse", {31'd0, bus.rd_valid}, 32'd0);

        // 2. full-word write then reads, back to back
        op(1'b1, 1'b0, 2'b11, 16'd3, 16'hA55A);
        check_eq("wr_no_valid", {31'd0, bus.rd_valid}, 32'd0);
        op(1'b0, 1'b1, 2'b00, 16'd3, 16'h0);
        check_eq("rd3", {16'd0, bus.data_out}, 32'hA55A);
        op(1'b0, 1'b1, 2'b00, 16'd4, 16'h0);
        check_eq("rd4", {16'd0, bus.data_out}, 32'h5A00);
        check_eq("rd4_valid", {31'd0, bus.rd_valid}, 32'd1);
        op(1'b0, 1'b0, 2'b00, 16'd0, 16'h0);
        check_eq("hold_data", {16'd0, bus.data_out}, 32'h5A00);

        // 3. wrap-around at the top of memory
        op(1'b1, 1'b0, 2'b11, 16'd15, 16'h1234);
        op(1'b0, 1'b1, 2'b00, 16'd15, 16'h0);
        check_eq("wrap_rd15", {16'd0, bus.data_out}, 32'h1234);
        op(1'b0, 1'b1, 2'b00, 16'd0, 16'h0);
        check_eq("wrap_rd0", {16'd0, bus.data_out}, 32'h3400);

        // 4. partial writes
        op(1'b1, 1'b0, 2'b01, 16'd3, 16'hFFEE);
        op(1'b0, 1'b1, 2'b00, 16'd3, 16'h0);
        check_eq("part_be01", {16'd0, bus.data_out}, 32'hA5EE);
        op(1'b1, 1'b0, 2'b00, 16'd3, 16'hFFEE);
        op(1'b0, 1'b1, 2'b00, 16'd3, 16'h0);
        check_eq("part_be00", {16'd0, bus.data_out}, 32'hA5EE);

        // 5. simultaneous read/write, then out-of-range requests
        op(1'b1, 1'b1, 2'b10, 16'd3, 16'hBEEF);
        check_eq("rw_bypass", {16'd0, bus.data_out}, 32'hBEEE);
        check_eq("rw_valid",  {31'd0, bus.rd_valid}, 32'd1);
        op(1'b0, 1'b1, 2'b00, 16'd3, 16'h0);
        check_eq("rw_mem", {16'd0, bus.data_out}, 32'hBEEE);
        op(1'b1, 1'b1, 2'b11, 16'd16, 16'h1111);
        check_eq("oor_err",      {31'd0, bus.addr_err}, 32'd1);
        check_eq("oor_no_valid", {31'd0, bus.rd_valid}, 32'd0);
        check_eq("oor_hold",     {16'd0, bus.data_out}, 32'hBEEE);
        op(1'b0, 1'b0, 2'b00, 16'd0, 16'h0);
        check_eq("oor_err_pulse", {31'd0, bus.addr_err}, 32'd0);
        op(1'b0, 1'b1, 2'b00, 16'h0103, 16'h0);
        check_eq("oor_hi_err",   {31'd0, bus.addr_err}, 32'd1);
        check_eq("oor_hi_valid", {31'd0, bus.rd_valid}, 32'd0);
        op(1'b1, 1'b0, 2'b11, 16'h1000, 16'h7777);
        check_eq("oor_wr_err", {31'd0, bus.addr_err}, 32'd1);
        op(1'b0, 1'b1, 2'b00, 16'd0, 16'h0);
        check_eq("oor_mem0", {16'd0, bus.data_out}, 32'h3400);
        op(1'b0, 1'b1, 2'b00, 16'd3, 16'h0);
        check_eq("oor_mem3", {16'd0, bus.data_out}, 32'hBEEE);

        // 6a. reset in IDLE with a read issued in the same cycle
        rst         = 1'b1;
        bus.rd_en   = 1'b1;
        bus.index   = 16'd3;
        @(posedge clk);
        #1;
        check_eq("rst_rd_valid2", {31'd0, bus.rd_valid}, 32'd0);
        check_eq("rst_data2",     {16'd0, bus.data_out}, 32'h0000);
        check_eq("rst_ready2",    {31'd0, bus.ready},    32'd0);
        rst       = 1'b0;
        bus.rd_en = 1'b0;
        @(posedge clk);
        #1;
        check_eq("aborted_rd_valid", {31'd0, bus.rd_valid}, 32'd0);

        // 6b. reset again at clear pointer 9, then a full sweep
        for (int i = 0; i < 8; i++) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_sweep("midclr_ready");
        op(1'b0, 1'b1, 2'b00, 16'd3, 16'h0);
        check_eq("post_clr_rd3", {16'd0, bus.data_out}, 32'h0000);
        check_eq("post_clr_valid", {31'd0, bus.rd_valid}, 32'd1);
        op(1'b0, 1'b1, 2'b00, 16'd15, 16'h0);
        check_eq("post_clr_rd15", {16'd0, bus.data_out}, 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/memorybank_multiport_word.md
Name: memorybank_multiport_word

Overview:
- Parametrised successor of the two-byte candidate memory bank.
- Byte-organised storage with configurable byte width, bytes per word and depth.
- Adds per-byte write enables, a registered read port with a valid strobe, wrap-around at the top of memory, out-of-range detection and a hardware clear sequence after reset.
- Sits beside the cluster/candidate logic as the shared scratch store for multi-byte node records.

Parameters:
- MEM_WIDTH, 8, bits per stored byte.
- BYTES_PER_WORD, 2, bytes accessed per read/write. Must be >= 1 and <= MEM_DEPTH.
- MEM_DEPTH, 16, number of byte locations. Any value >= 2.
- ADDR_WIDTH, 16, width of the index port.
- WORD_WIDTH (derived, not overridable), MEM_WIDTH*BYTES_PER_WORD.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- byte_en  in  BYTES_PER_WORD  per-byte write enable. Bit BYTES_PER_WORD-1 maps to the MSB byte.
- index  in  ADDR_WIDTH  byte address of the word's MSB byte.
- data_in  in  WORD_WIDTH  write data.
- data_out  out  WORD_WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse: data_out was updated this cycle.
- ready  out  1  high when the bank accepts requests.
- addr_err  out  1  one-cycle pulse: the previous request had index >= MEM_DEPTH.

Behaviour:
- Reset (rst high at an edge):
  - data_out=0, rd_valid=0, addr_err=0, ready=0.
  - State goes to CLEAR with clear pointer = 0.
  - rst asserted in any state, including mid-CLEAR, restarts the sequence from pointer 0.
  - A pending read is discarded; no rd_valid is produced for it.
- State CLEAR:
  - Each edge with rst low writes 0 to memory[ptr], then ptr++.
  - On the edge that clears location MEM_DEPTH-1, state goes to IDLE and ready goes to 1.
  - With defaults, ready is 1 after exactly 16 edges with rst low.
  - wr_en/rd_en are ignored while ready=0: no writes, no rd_valid, no addr_err.
- State IDLE: serves requests. There is no other state.
- Byte mapping:
  - Word byte k (k=0 is the MSB, data_in[WORD_WIDTH-1 -: MEM_WIDTH]) lives at location (index+k) mod MEM_DEPTH.
  - A word starting near the top wraps to location 0.
- Write (wr_en=1, ready=1, index < MEM_DEPTH):
  - At the edge, each byte k with its enable bit set is stored.
  - Bytes with a clear enable bit are untouched.
  - byte_en=0 is a legal no-op.
- Read (rd_en=1, ready=1, index < MEM_DEPTH):
  - data_out is loaded at that edge, giving a 1-cycle latency.
  - rd_valid=1 for that cycle only.
  - data_out holds its value until the next valid read or reset.
- Simultaneous read and write in the same cycle:
  - Write-first per byte: data_out shows data_in for enabled bytes and prior memory contents for the others.
  - Same-cycle bypass applies only where the read and write byte locations overlap. The read uses the same index as the write, so all bytes overlap.
- Out-of-range (index >= MEM_DEPTH with wr_en or rd_en, ready=1):
  - No memory change, no data_out change, rd_valid=0.
  - addr_err=1 on the next cycle for one cycle.
- Back-to-back requests every cycle are supported with no bubbles.
- Arithmetic:
  - The index is compared at full ADDR_WIDTH and never truncated before the range check.
  - The wrap sum is computed with at least one extra bit, then reduced mod MEM_DEPTH. This must be correct for non-power-of-two depths.

Test Plan:
1. Clear sequence: rst high 1 cycle, then low. ready=0 for 15 edges and 1 after the 16th. Read index 7 then gives data_out=0x0000 with rd_valid pulsing once.
2. Full-word write/read: write 0xA55A at index 3, byte_en=2'b11, then read index 3 -> data_out=0xA55A one cycle later. Read index 4 -> 0x5A00.
3. Wrap-around: write 0x1234 at index 15 -> mem[15]=0x12, mem[0]=0x34. Read index 15 -> 0x1234. Read index 0 -> 0x3400 (mem[1]=0).
4. Partial write: over 0xA55A at index 3, write 0xFFEE with byte_en=2'b01. Read -> 0xA5EE. Same write with byte_en=2'b00 -> still 0xA5EE.
5. Simultaneous rd/wr: wr_en=rd_en=1, index 3, data_in=0xBEEF, byte_en=2'b10 -> data_out=0xBEEE next cycle and memory holds 0xBEEE. With index=16 -> addr_err pulse, rd_valid=0, memory unchanged.
6. Reset mid-operation: assert rst at clear pointer 9, and again while a read is issued in IDLE. The pointer restarts at 0 and ready re-rises 16 edges after rst falls. No rd_valid for the aborted read. data_out=0 after reset.
